// File: rtl/pll_lock_supervisor.sv
// Reset/lock supervisor for the refclk-driven PLL: pulses pll_rst, qualifies lock,
// retries on timeout, and publishes a registered clk_ready for the downstream domain.
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int MAX_RETRIES      = 4,
  parameter int CNT_W            = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             retry_req,
  output logic             pll_rst,
  output logic             clk_ready,
  output logic             lock_fail,
  output logic [CNT_W-1:0] relock_count
);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_READY,
    S_FAIL
  } state_t;

  localparam int T_AB  = (RST_PULSE_CYC > LOCK_STABLE_CYC) ? RST_PULSE_CYC : LOCK_STABLE_CYC;
  localparam int T_MAX = (T_AB > LOCK_TIMEOUT_CYC) ? T_AB : LOCK_TIMEOUT_CYC;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int AW    = $clog2(MAX_RETRIES + 1);

  localparam logic [TW-1:0]    RST_LAST    = TW'(RST_PULSE_CYC - 1);
  localparam logic [TW-1:0]    STABLE_LAST = TW'(LOCK_STABLE_CYC - 1);
  localparam logic [TW-1:0]    TO_LAST     = TW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [AW-1:0]    ATT_MAX     = AW'(MAX_RETRIES);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state_reg, state_next;
  logic [TW-1:0]    timer_reg, timer_next;
  logic [AW-1:0]    attempt_reg, attempt_next;
  logic [CNT_W-1:0] relock_reg, relock_next;
  logic             pll_rst_reg, pll_rst_next;
  logic             clk_ready_reg, clk_ready_next;
  logic             lock_fail_reg, lock_fail_next;
  logic             sync1_reg, locked_s_reg;

  // pll_locked is asynchronous to refclk; only locked_s_reg is used below.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1_reg    <= 1'b0;
      locked_s_reg <= 1'b0;
    end else begin
      sync1_reg    <= pll_locked;
      locked_s_reg <= sync1_reg;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_RESET_PLL;
      timer_reg     <= '0;
      attempt_reg   <= '0;
      relock_reg    <= '0;
      pll_rst_reg   <= 1'b1;
      clk_ready_reg <= 1'b0;
      lock_fail_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      attempt_reg   <= attempt_next;
      relock_reg    <= relock_next;
      pll_rst_reg   <= pll_rst_next;
      clk_ready_reg <= clk_ready_next;
      lock_fail_reg <= lock_fail_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    attempt_next = attempt_reg;
    case (state_reg)
      S_RESET_PLL: begin
        if (timer_reg == RST_LAST) state_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (locked_s_reg) begin
          state_next = S_STABLE;
        end else if (timer_reg == TO_LAST) begin
          attempt_next = attempt_reg + AW'(1);
          state_next   = (attempt_reg + AW'(1) == ATT_MAX) ? S_FAIL : S_RESET_PLL;
        end
      end
      S_STABLE: begin
        if (!locked_s_reg) begin
          state_next = S_WAIT_LOCK;
        end else if (timer_reg == STABLE_LAST) begin
          state_next   = S_READY;
          attempt_next = '0;
        end
      end
      S_READY: begin
        if (!locked_s_reg) state_next = S_RESET_PLL;
      end
      S_FAIL: begin
        if (retry_req) begin
          state_next   = S_RESET_PLL;
          attempt_next = '0;
        end
      end
      default: state_next = S_RESET_PLL;
    endcase
  end

  always_comb begin
    timer_next     = (state_next != state_reg) ? '0 : timer_reg + TW'(1);
    relock_next    = relock_reg;
    if (state_reg == S_READY && state_next == S_RESET_PLL && relock_reg != CNT_MAX)
      relock_next = relock_reg + CNT_W'(1);
    pll_rst_next   = (state_next == S_RESET_PLL) || (state_next == S_FAIL);
    clk_ready_next = (state_next == S_READY);
    lock_fail_next = (state_next == S_FAIL);
  end

  assign pll_rst      = pll_rst_reg;
  assign clk_ready    = clk_ready_reg;
  assign lock_fail    = lock_fail_reg;
  assign relock_count = relock_reg;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: cycle vector table with scoreboard, plus
// hand-written saturation and asynchronous-reset sequences.
module tb_pll_lock_supervisor;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       retry_req;
  logic       pll_rst;
  logic       clk_ready;
  logic       lock_fail;
  logic [7:0] relock_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic locked;
    logic retry;
    int   n;
    logic e_rst;
    logic e_rdy;
    logic e_fail;
    int   e_cnt;
  } vec_t;

  typedef struct {
    int   idx;
    logic e_rst;
    logic e_rdy;
    logic e_fail;
    int   e_cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  pll_lock_supervisor #(
    .RST_PULSE_CYC(4), .LOCK_STABLE_CYC(8), .LOCK_TIMEOUT_CYC(20),
    .MAX_RETRIES(2), .CNT_W(8)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .retry_req(retry_req),
    .pll_rst(pll_rst), .clk_ready(clk_ready), .lock_fail(lock_fail),
    .relock_count(relock_count)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic lk, input logic rt, input int n,
                     input logic r, input logic y, input logic f, input int c);
    vec_t v;
    v.locked = lk; v.retry = rt; v.n = n;
    v.e_rst = r; v.e_rdy = y; v.e_fail = f; v.e_cnt = c;
    vecs.push_back(v);
  endtask

  // Bounded wait for a level on clk_ready (0), pll_rst (1) or lock_fail (2).
  task automatic wait_sig(input int sel, input logic val, input int budget, input string nm);
    logic cur;
    cur = (sel == 0) ? clk_ready : (sel == 1) ? pll_rst : lock_fail;
    for (int k = 0; k < budget && cur != val; k++) begin
      @(posedge refclk); #1;
      cur = (sel == 0) ? clk_ready : (sel == 1) ? pll_rst : lock_fail;
    end
    chk(nm, int'(cur), int'(val));
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; pll_locked = 1'b0; retry_req = 1'b0;

    // Clean lock, then retry_req in READY ignored.
    add(0,0,3, 1,0,0,0); add(0,0,3, 0,0,0,0); add(1,0,10, 0,0,0,0);
    add(1,0,2, 0,1,0,0); add(1,1,1, 0,1,0,0); add(1,0,1, 0,1,0,0);
    // Loss of lock in READY, then glitch during STABLE.
    add(0,0,2, 0,1,0,0); add(0,0,1, 1,0,0,1); add(0,0,3, 1,0,0,1); add(0,0,1, 0,0,0,1);
    add(1,0,2, 0,0,0,1); add(1,0,5, 0,0,0,1); add(0,0,2, 0,0,0,1);
    add(1,0,10, 0,0,0,1); add(1,0,1, 0,1,0,1);
    // Timeouts -> FAIL; pll_locked activity ignored in FAIL.
    add(0,0,2, 0,1,0,1); add(0,0,1, 1,0,0,2); add(0,0,3, 1,0,0,2); add(0,0,20, 0,0,0,2);
    add(0,0,4, 1,0,0,2); add(0,0,20, 0,0,0,2); add(0,0,1, 1,0,1,2);
    add(1,0,5, 1,0,1,2); add(0,0,3, 1,0,1,2); add(1,0,4, 1,0,1,2);
    // FAIL recovery via retry_req, READY reached, retry in READY ignored.
    add(1,1,1, 1,0,0,2); add(1,0,3, 1,0,0,2); add(1,0,9, 0,0,0,2); add(1,0,1, 0,1,0,2);
    add(1,1,1, 0,1,0,2); add(1,0,2, 0,1,0,2);
    // Lock and timeout coincide: lock wins.
    add(0,0,2, 0,1,0,2); add(0,0,1, 1,0,0,3); add(0,0,3, 1,0,0,3); add(0,0,18, 0,0,0,3);
    add(1,0,2, 0,0,0,3); add(1,0,8, 0,0,0,3); add(1,0,1, 0,1,0,3);

    repeat (3) @(posedge refclk);
    #1;
    chk("reset.pll_rst", int'(pll_rst), 1);
    chk("reset.clk_ready", int'(clk_ready), 0);
    chk("reset.lock_fail", int'(lock_fail), 0);
    chk("reset.relock_count", int'(relock_count), 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        pll_locked = vecs[i].locked;
        retry_req  = (j == 0) ? vecs[i].retry : 1'b0;
        e.idx = i; e.e_rst = vecs[i].e_rst; e.e_rdy = vecs[i].e_rdy;
        e.e_fail = vecs[i].e_fail; e.e_cnt = vecs[i].e_cnt;
        sb.push_back(e);
        @(posedge refclk); #1;
        e = sb.pop_front();
        chk($sformatf("vec%0d.%0d.pll_rst", e.idx, j), int'(pll_rst), int'(e.e_rst));
        chk($sformatf("vec%0d.%0d.clk_ready", e.idx, j), int'(clk_ready), int'(e.e_rdy));
        chk($sformatf("vec%0d.%0d.lock_fail", e.idx, j), int'(lock_fail), int'(e.e_fail));
        chk($sformatf("vec%0d.%0d.relock_count", e.idx, j), int'(relock_count), e.e_cnt);
      end
    end
    retry_req = 1'b0;

    // 260 more loss-of-lock events from READY; count saturates at 255.
    for (int i = 0; i < 260; i++) begin
      pll_locked = 1'b0;
      wait_sig(0, 1'b0, 10, "sat.ready_drop");
      wait_sig(1, 1'b0, 10, "sat.rst_release");
      pll_locked = 1'b1;
      wait_sig(0, 1'b1, 30, "sat.ready_rise");
      if (i == 0) chk("sat.first", int'(relock_count), 4);
    end
    chk("sat.final", int'(relock_count), 255);

    // Asynchronous reset mid-STABLE.
    pll_locked = 1'b0;
    wait_sig(1, 1'b1, 10, "midstable.rst_rise");
    wait_sig(1, 1'b0, 10, "midstable.rst_fall");
    pll_locked = 1'b1;
    repeat (5) @(posedge refclk);
    #1;
    chk("midstable.pre_ready", int'(clk_ready), 0);
    chk("midstable.pre_rst", int'(pll_rst), 0);
    chk("midstable.pre_cnt", int'(relock_count), 255);
    #2 rst = 1'b1;
    #1;
    chk("midstable.async.pll_rst", int'(pll_rst), 1);
    chk("midstable.async.clk_ready", int'(clk_ready), 0);
    chk("midstable.async.lock_fail", int'(lock_fail), 0);
    chk("midstable.async.relock_count", int'(relock_count), 0);
    pll_locked = 1'b0;
    @(posedge refclk); #1;
    rst = 1'b0;

    // Asynchronous reset mid-FAIL.
    wait_sig(2, 1'b1, 200, "midfail.reach");
    chk("midfail.pll_rst", int'(pll_rst), 1);
    #2 rst = 1'b1;
    #1;
    chk("midfail.async.pll_rst", int'(pll_rst), 1);
    chk("midfail.async.clk_ready", int'(clk_ready), 0);
    chk("midfail.async.lock_fail", int'(lock_fail), 0);
    chk("midfail.async.relock_count", int'(relock_count), 0);
    @(posedge refclk); #1;
    rst = 1'b0;
    repeat (2) @(posedge refclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
